// File: rtl/f_div_seq.sv
// Sequenced IEEE-754 binary32 divider: special-case decode, one quotient bit per
// cycle shift-subtract recurrence, then normalise/round, over valid/ready handshakes.
module f_div_seq #(
  parameter int          QBITS      = 26,
  parameter logic [2:0]  RM_DEFAULT = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rounding,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic [4:0]  flags
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [2:0] {S_IDLE, S_SPEC, S_DIV, S_RND, S_DONE} state_t;

  state_t state, nxt;

  logic              sign;
  logic [2:0]        rm;
  logic signed [9:0] e;
  logic [23:0]       mb;
  logic [24:0]       r;
  logic [QBITS-1:0]  q;
  logic [CW-1:0]     count;
  logic              an, bn, ai, bi, az, bz;

  // Operand classification; subnormals decode as zero (DAZ).
  logic a_emax, b_emax, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_special;
  assign a_emax    = &a[30:23];
  assign b_emax    = &b[30:23];
  assign a_nan     = a_emax & (|a[22:0]);
  assign b_nan     = b_emax & (|b[22:0]);
  assign a_inf     = a_emax & ~(|a[22:0]);
  assign b_inf     = b_emax & ~(|b[22:0]);
  assign a_zero    = ~(|a[30:23]);
  assign b_zero    = ~(|b[30:23]);
  assign a_special = a_emax | b_emax | a_zero | b_zero;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; flush overrides both and also masks an input transfer while idle.
  logic accept;
  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (flush && state != S_IDLE) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) nxt = a_special ? S_SPEC : S_DIV;
        S_SPEC:  nxt = S_DONE;
        S_DIV:   if (count == CW'(QBITS - 1)) nxt = S_RND;
        S_RND:   nxt = S_DONE;
        S_DONE:  if (out_ready) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Recurrence step; the remainder stays below 2*mb so 25 bits suffice.
  logic        r_ge;
  logic [24:0] r_sub;
  assign r_ge  = (r >= {1'b0, mb});
  assign r_sub = r - {1'b0, mb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign  <= 1'b0;
      rm    <= 3'b000;
      e     <= '0;
      mb    <= '0;
      r     <= '0;
      q     <= '0;
      count <= '0;
      {an, bn, ai, bi, az, bz} <= '0;
    end else if (accept) begin
      sign  <= a[31] ^ b[31];
      rm    <= (rounding > 3'b100) ? RM_DEFAULT : rounding;
      e     <= $signed({2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127);
      mb    <= {~b_zero, b[22:0]};
      r     <= {1'b0, ~a_zero, a[22:0]};
      q     <= '0;
      count <= '0;
      {an, bn, ai, bi, az, bz} <= {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero};
    end else if (state == S_DIV) begin
      r     <= r_ge ? (r_sub << 1) : (r << 1);
      q     <= {q[QBITS-2:0], r_ge};
      count <= count + 1'b1;
    end
  end

  logic [31:0] spec_y;
  logic [4:0]  spec_fl;
  always_comb begin
    spec_y  = {sign, 31'd0};
    spec_fl = 5'b00000;
    if (an | bn | (az & bz) | (ai & bi)) begin
      spec_y  = 32'h7FC00000;
      spec_fl = 5'b10000;
    end else if (ai) begin
      spec_y  = {sign, 8'hFF, 23'd0};
    end else if (bz) begin
      spec_y  = {sign, 8'hFF, 23'd0};
      spec_fl = 5'b01000;
    end
  end

  // Normalise, round and range-check the finished quotient.
  logic [23:0]       mant;
  logic              g, s, inc, ovf_inf;
  logic signed [9:0] en, er;
  logic [24:0]       sum;
  logic [22:0]       frac_r;
  logic [31:0]       rnd_y;
  logic [4:0]        rnd_fl;
  always_comb begin
    if (q[QBITS-1]) begin
      mant = q[QBITS-1 -: 24];
      g    = q[QBITS-25];
      s    = (|q[QBITS-26:0]) | (|r);
      en   = e;
    end else begin
      mant = q[QBITS-2 -: 24];
      g    = q[QBITS-26];
      s    = |r;
      en   = e - 10'sd1;
    end
    case (rm)
      3'b000:  inc = g & (s | mant[0]);
      3'b010:  inc = (g | s) & sign;
      3'b011:  inc = (g | s) & ~sign;
      3'b100:  inc = g;
      default: inc = 1'b0;
    endcase
    sum     = {1'b0, mant} + {24'd0, inc};
    frac_r  = sum[24] ? sum[23:1] : sum[22:0];
    er      = sum[24] ? en + 10'sd1 : en;
    ovf_inf = (rm == 3'b000) | (rm == 3'b100) | ((rm == 3'b011) & ~sign) | ((rm == 3'b010) & sign);
    if (er >= 10'sd255) begin
      rnd_y  = ovf_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
      rnd_fl = 5'b00101;
    end else if (er <= 10'sd0) begin
      rnd_y  = {sign, 31'd0};
      rnd_fl = 5'b00011;
    end else begin
      rnd_y  = {sign, er[7:0], frac_r};
      rnd_fl = {4'b0000, g | s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      flags <= '0;
    end else if (nxt == S_DONE && state != S_DONE) begin
      y     <= (state == S_SPEC) ? spec_y  : rnd_y;
      flags <= (state == S_SPEC) ? spec_fl : rnd_fl;
    end
  end

endmodule

// File: doc/f_div_seq.md
Name: f_div_seq

Overview:
- Multi-cycle sequencer for IEEE-754 binary32 division: accepts a, b and a rounding mode over a valid/ready handshake, decodes special cases, and runs a shift-subtract mantissa recurrence.
- Normalises, rounds, and returns the result plus exception flags over a second valid/ready handshake.
- Sits between the FPU issue stage and writeback. It is the area-cheap, sequenced division path that backs the F-unit divide opcode.

Parameters:
- QBITS, 26, quotient bits generated per operation (24 significand + 1 normalisation + 1 guard); the sticky bit is taken from the remainder.
- RM_DEFAULT, 3'b000, rounding mode substituted when an illegal mode (101..111) arrives.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  sequencer can accept operands.
- a  in  32  dividend, binary32.
- b  in  32  divisor, binary32.
- rounding  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- flush  in  1  synchronous abort; discards any operation in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  32  quotient, binary32.
- flags  out  5  [4] NV, [3] DZ, [2] OF, [1] UF, [0] NX.

Behaviour:
- **Reset (async, rst_n=0):**
  - state=IDLE, in_ready=1, out_valid=0, y=0, flags=0.
  - Internal counter, remainder and quotient registers are cleared.
  - Reset asserted mid-operation discards that operation with no output.
- **States:** IDLE, SPEC, DIV, RND, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready, latch sign=a[31]^b[31], exponents, mantissas with hidden bit, and rounding (illegal values are replaced by RM_DEFAULT).
  - Subnormal inputs are treated as signed zero (DAZ).
  - Go to SPEC if either operand is NaN, Inf or zero; otherwise go to DIV with count=0.
- **SPEC (1 cycle):** produces the result, then goes to DONE.
  - Any NaN, 0/0 or Inf/Inf: y=0x7FC00000, NV. A signalling NaN also raises NV; the output is always the canonical NaN.
  - finite/0: signed Inf, DZ.
  - Inf/x: signed Inf, no flags.
  - 0/x or x/Inf: signed zero, no flags.
- **DIV (QBITS cycles):**
  - One quotient bit per cycle: remainder r starts as ma (25 bits). If r>=mb then r=(r-mb)<<1 and q bit=1; otherwise r=r<<1 and q bit=0.
  - The count increments each cycle; exit to RND after count=QBITS-1.
  - Exponent: e = ea - eb + 127, computed as 10-bit signed.
- **RND (1 cycle):**
  - If q[25]=0, shift left by 1 and decrement e.
  - sticky = (r!=0).
  - Round using guard/sticky/lsb per mode. A mantissa carry-out increments e.
  - If e>=255: overflow result is Inf for RNE/RMM and for directed modes toward the sign; otherwise it is max-finite (0x7F7FFFFF, sign applied). Raise OF|NX.
  - If e<=0: flush to signed zero and raise UF|NX.
  - Otherwise NX = guard|sticky.
- **DONE:**
  - out_valid=1; y and flags are held stable until out_ready.
  - On out_valid&out_ready, return to IDLE; in_ready rises the next cycle (no same-cycle accept in DONE).
- **Latency** (accept edge = cycle 0):
  - Normal operands: out_valid at cycle QBITS+2 = 28.
  - Special operands: out_valid at cycle 2.
- **Throughput:** one operation in flight at a time; in_ready=0 in every state except IDLE.
- **flush:**
  - In any non-IDLE state, flush returns to IDLE next cycle with out_valid=0; the result is lost.
  - flush in IDLE has no effect, and a same-cycle in_valid is ignored.
  - flush has priority over both handshakes.
- **Registered outputs:** y and flags are registered, update only on entry to DONE, and keep their last value after the handshake.

Test Plan:
- **Normal divide, sign rule:** a=0x40C00000 (6.0), b=0x40000000, RNE -> y=0x40400000, flags=0, out_valid at cycle 28. The same with a=0xC0C00000 -> y=0xC0400000.
- **Inexact rounding:** a=0x3F800000, b=0x40400000 (1/3).
  - RNE -> 0x3EAAAAAB, flags=00001.
  - RTZ -> 0x3EAAAAAA, flags=00001.
  - Illegal mode 111 behaves as RNE.
- **Specials** (out_valid at cycle 2):
  - 1.0/0x00000000 -> 0x7F800000, DZ.
  - 0/0 -> 0x7FC00000, NV.
  - 0x7F800000/0x7F800000 -> 0x7FC00000, NV.
  - 0x7FA00000 (sNaN)/1.0 -> 0x7FC00000, NV.
- **Overflow/underflow:**
  - 0x7F7FFFFF/0x3F000000: RNE -> 0x7F800000, flags=00101; RTZ -> 0x7F7FFFFF, flags=00101.
  - 0x00800000/0x40000000 -> 0x00000000, flags=00011.
- **Handshake backpressure:**
  - Hold out_ready=0 for 10 cycles after out_valid -> y and flags are stable and in_ready=0 throughout.
  - Then out_ready=1 -> in_ready=1 on the next cycle; back-to-back operations are accepted.
- **Abort and reset:**
  - flush at cycle 10 of DIV -> no out_valid; IDLE on the next cycle; a following 6.0/2.0 completes correctly.
  - rst_n pulsed low at cycle 15 -> all outputs return to reset values immediately, without waiting for a clock edge.
